cam_pixel_capture: RTL and testbench



---
 rtl/cam_pkg.sv | 34 +++
 rtl/pix_fifo.sv | 56 +++++
 rtl/cam_pixel_capture.sv | 216 +++++++++++++++++++++
 tb/tb_cam_pixel_capture.sv | 326 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/cam_pkg.sv
// Shared types and constants for the camera capture path.
package cam_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StWaitVs,
    StWaitVsLow,
    StActive
  } cap_state_e;

  // FIFO entry layout: {sof, eol, rgb565}
  localparam int unsigned PixEntryW = 18;
  localparam int unsigned SofBit    = 17;
  localparam int unsigned EolBit    = 16;

  // RGB565 field positions within the 16-bit pixel
  localparam int unsigned RMsb = 15;
  localparam int unsigned RLsb = 11;
  localparam int unsigned GMsb = 10;
  localparam int unsigned GLsb = 5;
  localparam int unsigned BMsb = 4;
  localparam int unsigned BLsb = 0;

  // Camera sends the high byte first: R[4:0] G[5:3] | G[2:0] B[4:0]
  function automatic logic [15:0] rgb565_pack(logic [7:0] hi, logic [7:0] lo);
    logic [15:0] p;
    p            = '0;
    p[RMsb:RLsb] = hi[7:3];
    p[GMsb:GLsb] = {hi[2:0], lo[7:5]};
    p[BMsb:BLsb] = lo[4:0];
    return p;
  endfunction

endpackage

// File: rtl/pix_fifo.sv
// Synchronous show-ahead FIFO; rdata is zero while empty.
module pix_fifo #(
  parameter int unsigned WIDTH = 18,
  parameter int unsigned DEPTH = 4
) (
  input  logic             clk_i,
  input  logic             reset_i,
  input  logic             push_i,
  input  logic [WIDTH-1:0] wdata_i,
  input  logic             pop_i,
  output logic [WIDTH-1:0] rdata_o,
  output logic             full_o,
  output logic             empty_o
);

  localparam int unsigned PtrW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [PtrW:0]    count_q;
  logic             do_push, do_pop;

  function automatic logic [PtrW-1:0] ptr_inc(logic [PtrW-1:0] p);
    return (p == PtrW'(DEPTH - 1)) ? '0 : p + PtrW'(1);
  endfunction

  assign empty_o = (count_q == '0);
  assign full_o  = (count_q == (PtrW + 1)'(DEPTH));
  assign do_pop  = pop_i & ~empty_o;
  // A push into a full FIFO is fine when the head leaves in the same cycle
  assign do_push = push_i & (~full_o | do_pop);
  assign rdata_o = empty_o ? '0 : mem_q[rd_ptr_q];

  // Pointer and occupancy bookkeeping
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= ptr_inc(wr_ptr_q);
      if (do_pop)  rd_ptr_q <= ptr_inc(rd_ptr_q);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + (PtrW + 1)'(1);
        2'b01:   count_q <= count_q - (PtrW + 1)'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage array, no reset needed since reads are masked while empty
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata_i;
  end

endmodule

// File: rtl/cam_pixel_capture.sv
// Samples the raw camera bus, builds RGB565 pixels with sof/eol tags and
// streams them out through a small FIFO while checking frame geometry.
module cam_pixel_capture
  import cam_pkg::*;
#(
  parameter int unsigned H_ACTIVE    = 640,
  parameter int unsigned V_ACTIVE    = 480,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        cam_pclk,
  input  logic        cam_vsync,
  input  logic        cam_href,
  input  logic [7:0]  cam_data,
  output logic        m_valid,
  input  logic        m_ready,
  output logic [15:0] m_data,
  output logic        m_sof,
  output logic        m_eol,
  output logic        frame_done,
  output logic [15:0] frame_count,
  output logic        line_err,
  output logic        overflow
);

  localparam int unsigned XW = $clog2(H_ACTIVE + 1);
  localparam int unsigned YW = $clog2(V_ACTIVE + 1);
  localparam logic [XW-1:0] XMax  = XW'(H_ACTIVE);
  localparam logic [XW-1:0] XLast = XW'(H_ACTIVE - 1);
  localparam logic [YW-1:0] YMax  = YW'(V_ACTIVE);

  // Synchronizers
  logic [SYNC_STAGES-1:0] pclk_sync_q, vsync_sync_q, href_sync_q;
  logic [7:0]             data_sync_q [SYNC_STAGES];
  logic                   pclk_s, vsync_s, href_s;
  logic [7:0]             data_s;

  // Shift every camera input through SYNC_STAGES flops
  always_ff @(posedge clk) begin
    if (reset) begin
      pclk_sync_q  <= '0;
      vsync_sync_q <= '0;
      href_sync_q  <= '0;
      for (int i = 0; i < int'(SYNC_STAGES); i++) data_sync_q[i] <= '0;
    end else begin
      pclk_sync_q  <= {pclk_sync_q[SYNC_STAGES-2:0], cam_pclk};
      vsync_sync_q <= {vsync_sync_q[SYNC_STAGES-2:0], cam_vsync};
      href_sync_q  <= {href_sync_q[SYNC_STAGES-2:0], cam_href};
      data_sync_q[0] <= cam_data;
      for (int i = 1; i < int'(SYNC_STAGES); i++) data_sync_q[i] <= data_sync_q[i-1];
    end
  end

  assign pclk_s  = pclk_sync_q[SYNC_STAGES-1];
  assign vsync_s = vsync_sync_q[SYNC_STAGES-1];
  assign href_s  = href_sync_q[SYNC_STAGES-1];
  assign data_s  = data_sync_q[SYNC_STAGES-1];

  // Edge detection; events are registered together with the byte and href
  // level so the FSM sees a consistent snapshot.
  logic       pclk_d_q, vsync_d_q, href_d_q;
  logic       pclk_rise_q, vs_rise_q, vs_fall_q, href_fall_q, href_q;
  logic [7:0] byte_q;

  // Delay the synced signals and register their edges
  always_ff @(posedge clk) begin
    if (reset) begin
      pclk_d_q    <= 1'b0;
      vsync_d_q   <= 1'b0;
      href_d_q    <= 1'b0;
      pclk_rise_q <= 1'b0;
      vs_rise_q   <= 1'b0;
      vs_fall_q   <= 1'b0;
      href_fall_q <= 1'b0;
      href_q      <= 1'b0;
      byte_q      <= '0;
    end else begin
      pclk_d_q    <= pclk_s;
      vsync_d_q   <= vsync_s;
      href_d_q    <= href_s;
      pclk_rise_q <= pclk_s & ~pclk_d_q;
      vs_rise_q   <= vsync_s & ~vsync_d_q;
      vs_fall_q   <= ~vsync_s & vsync_d_q;
      href_fall_q <= ~href_s & href_d_q;
      href_q      <= href_s;
      byte_q      <= data_s;
    end
  end

  // Capture FSM state
  cap_state_e    state_q;
  logic [XW-1:0] x_q;
  logic [YW-1:0] y_q;
  logic          phase_q;
  logic [7:0]    hi_q;
  logic          sof_arm_q;
  logic          pix_valid_q;
  logic [15:0]   pix_data_q;
  logic          pix_sof_q, pix_eol_q;

  // Frame/line tracking, byte pairing and geometry checks
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      x_q         <= '0;
      y_q         <= '0;
      phase_q     <= 1'b0;
      hi_q        <= '0;
      sof_arm_q   <= 1'b0;
      pix_valid_q <= 1'b0;
      pix_data_q  <= '0;
      pix_sof_q   <= 1'b0;
      pix_eol_q   <= 1'b0;
      frame_done  <= 1'b0;
      frame_count <= '0;
      line_err    <= 1'b0;
    end else begin
      pix_valid_q <= 1'b0;
      frame_done  <= 1'b0;
      if (!enable) begin
        // Drop any half-built pixel; buffered pixels keep draining
        state_q <= StIdle;
        phase_q <= 1'b0;
      end else begin
        unique case (state_q)
          StIdle: state_q <= StWaitVs;
          // Wait for a frame boundary so a running frame is never captured partially
          StWaitVs: if (vs_rise_q) state_q <= StWaitVsLow;
          StWaitVsLow: begin
            if (vs_fall_q) begin
              state_q   <= StActive;
              x_q       <= '0;
              y_q       <= '0;
              phase_q   <= 1'b0;
              line_err  <= 1'b0;
              sof_arm_q <= 1'b1;
            end
          end
          StActive: begin
            if (vs_rise_q) begin
              frame_done  <= 1'b1;
              frame_count <= frame_count + 16'd1;
              if (y_q != YMax) line_err <= 1'b1;
              state_q <= StWaitVsLow;
            end else if (href_fall_q) begin
              if (x_q != XMax || phase_q) line_err <= 1'b1;
              if (x_q != '0 && y_q < YMax) y_q <= y_q + YW'(1);
              x_q     <= '0;
              phase_q <= 1'b0;
            end else if (pclk_rise_q && href_q) begin
              if (y_q >= YMax) begin
                // Extra lines are discarded whole
                line_err <= 1'b1;
              end else if (!phase_q) begin
                hi_q    <= byte_q;
                phase_q <= 1'b1;
              end else begin
                phase_q <= 1'b0;
                if (x_q >= XMax) begin
                  line_err <= 1'b1;
                end else begin
                  pix_valid_q <= 1'b1;
                  pix_data_q  <= rgb565_pack(hi_q, byte_q);
                  pix_sof_q   <= sof_arm_q;
                  pix_eol_q   <= (x_q == XLast);
                  sof_arm_q   <= 1'b0;
                  x_q         <= x_q + XW'(1);
                end
              end
            end
          end
          default: state_q <= StIdle;
        endcase
      end
    end
  end

  // Output FIFO
  logic                 fifo_full, fifo_empty, fifo_push, fifo_pop;
  logic [PixEntryW-1:0] fifo_rdata;

  assign fifo_pop  = m_valid & m_ready;
  assign fifo_push = pix_valid_q & (~fifo_full | fifo_pop);

  pix_fifo #(
    .WIDTH(PixEntryW),
    .DEPTH(FIFO_DEPTH)
  ) u_fifo (
    .clk_i  (clk),
    .reset_i(reset),
    .push_i (fifo_push),
    .wdata_i({pix_sof_q, pix_eol_q, pix_data_q}),
    .pop_i  (fifo_pop),
    .rdata_o(fifo_rdata),
    .full_o (fifo_full),
    .empty_o(fifo_empty)
  );

  assign m_valid = ~fifo_empty;
  assign m_data  = fifo_rdata[15:0];
  assign m_sof   = fifo_rdata[SofBit];
  assign m_eol   = fifo_rdata[EolBit];

  // Sticky overflow when a finished pixel finds no room
  always_ff @(posedge clk) begin
    if (reset) begin
      overflow <= 1'b0;
    end else if (pix_valid_q && fifo_full && !fifo_pop) begin
      overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_cam_pixel_capture.sv
// Scoreboard bench: stimulus tasks push expected pixels, a monitor pops them.
module tb_cam_pixel_capture;

  localparam int H     = 4;
  localparam int V     = 2;
  localparam int DEPTH = 4;
  localparam int SYNC  = 2;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        enable = 1'b0;
  logic        cam_pclk = 1'b0;
  logic        cam_vsync = 1'b0;
  logic        cam_href = 1'b0;
  logic [7:0]  cam_data = 8'h00;
  logic        m_valid, m_sof, m_eol, frame_done, line_err, overflow;
  logic        m_ready = 1'b0;
  logic [15:0] m_data, frame_count;

  always #5 clk = ~clk;

  cam_pixel_capture #(
    .H_ACTIVE   (H),
    .V_ACTIVE   (V),
    .FIFO_DEPTH (DEPTH),
    .SYNC_STAGES(SYNC)
  ) dut (
    .clk        (clk),
    .reset      (reset),
    .enable     (enable),
    .cam_pclk   (cam_pclk),
    .cam_vsync  (cam_vsync),
    .cam_href   (cam_href),
    .cam_data   (cam_data),
    .m_valid    (m_valid),
    .m_ready    (m_ready),
    .m_data     (m_data),
    .m_sof      (m_sof),
    .m_eol      (m_eol),
    .frame_done (frame_done),
    .frame_count(frame_count),
    .line_err   (line_err),
    .overflow   (overflow)
  );

  int          total = 0;
  int          bad = 0;
  logic [17:0] exp_q[$];
  bit          hold = 0;
  int          stored = 0;
  // Reference model of the capture path, in frame/line terms
  bit          m_en = 0, m_cap = 0, m_first = 0, m_err = 0, m_ovf = 0;
  int          m_y = 0, m_frames = 0;
  int          fd_pulses = 0, fd_cycles = 0;
  logic        fd_prev = 1'b0;
  int          lat = 0;
  logic [7:0]  pat [4] = '{8'hF8, 8'h00, 8'h07, 8'hE0};
  int          len_pick [7] = '{2*H, 2*H, 2*H, 2*H-1, 2*H+1, 2*H+2, 2};

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Consumer: random backpressure unless the bench is holding the stream
  initial forever begin
    @(posedge clk);
    #1;
    m_ready = hold ? 1'b0 : ($urandom_range(0, 3) != 0);
  end

  // Monitor: compare every accepted pixel and count frame_done pulses
  initial forever begin
    logic [17:0] e;
    @(negedge clk);
    if (!reset) begin
      if (m_valid && m_ready) begin
        total++;
        if (exp_q.size() == 0) begin
          bad++;
          $display("FAIL pixel: unexpected %05h", {m_sof, m_eol, m_data});
        end else begin
          e = exp_q.pop_front();
          if ({m_sof, m_eol, m_data} !== e) begin
            bad++;
            $display("FAIL pixel: got {sof,eol,data}=%05h expected %05h",
                     {m_sof, m_eol, m_data}, e);
          end
        end
      end
      if (frame_done) fd_cycles++;
      if (frame_done && !fd_prev) fd_pulses++;
    end
    fd_prev = frame_done;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  task automatic expect_pixel(input logic [15:0] d, input bit sof, input bit eol);
    if (hold) begin
      if (stored < DEPTH) begin
        exp_q.push_back({sof, eol, d});
        stored++;
      end else begin
        m_ovf = 1;
      end
    end else begin
      exp_q.push_back({sof, eol, d});
    end
  endtask

  task automatic cam_byte(input logic [7:0] b, input bit measure);
    cam_data = b;
    tick(3);
    cam_pclk = 1'b1;
    for (int i = 1; i <= 6; i++) begin
      @(posedge clk);
      #1;
      if (i == 3) cam_pclk = 1'b0;
      if (measure && lat == 0 && m_valid) lat = i;
    end
  endtask

  // One href line; the model decides which pixels must appear
  task automatic send_line(input int nbytes, input bit fixed, input int drop_at,
                           input int raise_at, input bit measure);
    logic [7:0]  hi, b;
    logic [15:0] d;
    int          px;
    int          r, g, bl;
    hi = 8'h00;
    px = 0;
    cam_href = 1'b1;
    tick(3);
    for (int i = 0; i < nbytes; i++) begin
      if (i == drop_at) begin
        enable = 1'b0; m_en = 0; m_cap = 0;
        tick(2);
      end
      if (i == raise_at) begin
        enable = 1'b1; m_en = 1;
        tick(2);
      end
      b = fixed ? pat[i % 4] : 8'($urandom);
      if (i % 2 == 0) begin
        hi = b;
      end else if (m_cap && m_y < V) begin
        if (px < H) begin
          if (fixed) begin
            d = (px % 2 == 0) ? 16'hF800 : 16'h07E0;
          end else begin
            r  = int'(hi) / 8;
            g  = (int'(hi) % 8) * 8 + int'(b) / 32;
            bl = int'(b) % 32;
            d  = 16'(r * 2048 + g * 32 + bl);
          end
          expect_pixel(d, m_first, px == H - 1);
          m_first = 0;
        end
        px++;
      end
      cam_byte(b, measure && i == 1);
    end
    cam_href = 1'b0;
    tick(4);
    if (m_cap) begin
      if (m_y >= V || nbytes != 2 * H) m_err = 1;
      if (m_y < V && px > 0) m_y++;
    end
  endtask

  task automatic vsync_pulse();
    cam_vsync = 1'b1;
    tick(8);
    if (m_en && m_cap) begin
      m_frames++;
      if (m_y != V) m_err = 1;
    end
    check("frame_count", int'(frame_count), m_frames % 65536);
    check("frame_done pulses", fd_pulses, m_frames);
    check("frame_done width", fd_cycles, m_frames);
    check("line_err at frame end", int'(line_err), int'(m_err));
    check("overflow", int'(overflow), int'(m_ovf));
    cam_vsync = 1'b0;
    tick(8);
    if (m_en) begin
      m_cap = 1; m_y = 0; m_err = 0; m_first = 1;
    end
    check("line_err after vs_fall", int'(line_err), int'(m_err));
  endtask

  task automatic wait_drain();
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 500) begin
      tick(1);
      n++;
    end
    total++;
    if (exp_q.size() != 0) begin
      bad++;
      $display("FAIL drain: %0d pixels missing after %0d cycles", exp_q.size(), n);
      exp_q.delete();
    end
    tick(3);
    check("m_valid when empty", int'(m_valid), 0);
    check("outputs zero when empty", int'({m_sof, m_eol, m_data}), 0);
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; hold = 0;
    cam_pclk = 1'b0; cam_vsync = 1'b0; cam_href = 1'b0; cam_data = 8'h00;
    tick(4);
    check("reset m_valid", int'(m_valid), 0);
    check("reset m_data", int'(m_data), 0);
    check("reset m_sof", int'(m_sof), 0);
    check("reset m_eol", int'(m_eol), 0);
    check("reset frame_done", int'(frame_done), 0);
    check("reset frame_count", int'(frame_count), 0);
    check("reset line_err", int'(line_err), 0);
    check("reset overflow", int'(overflow), 0);
    m_en = 0; m_cap = 0; m_first = 0; m_err = 0; m_ovf = 0; m_y = 0; m_frames = 0;
    exp_q.delete(); stored = 0;
    fd_pulses = 0; fd_cycles = 0;
    reset = 1'b0;
    tick(2);
  endtask

  initial begin
    do_reset();

    // Fixed-colour frame with latency measurement on the first pixel
    enable = 1'b1; m_en = 1;
    tick(4);
    vsync_pulse();
    lat = 0;
    send_line(2 * H, 1, -1, -1, 1);
    check("first pixel latency", lat, SYNC + 3);
    send_line(2 * H, 1, -1, -1, 0);
    vsync_pulse();
    wait_drain();

    // Random frames with assorted line lengths and counts
    for (int f = 0; f < 6; f++) begin
      int nl;
      nl = $urandom_range(1, 3);
      for (int l = 0; l < nl; l++) send_line(len_pick[$urandom_range(0, 6)], 0, -1, -1, 0);
      vsync_pulse();
      wait_drain();
    end

    // Frame with a single line
    send_line(2 * H, 0, -1, -1, 0);
    vsync_pulse();
    wait_drain();

    // Odd-byte line and over-long line
    send_line(2 * H + 1, 0, -1, -1, 0);
    send_line(2 * H + 2, 0, -1, -1, 0);
    vsync_pulse();
    wait_drain();

    // Enable raised in the middle of a running frame
    do_reset();
    vsync_pulse();
    send_line(2 * H, 0, -1, 3, 0);
    send_line(2 * H, 0, -1, -1, 0);
    vsync_pulse();
    send_line(2 * H, 0, -1, -1, 0);
    send_line(2 * H, 0, -1, -1, 0);
    vsync_pulse();
    wait_drain();

    // Enable dropped before the second byte of a pixel with pixels buffered
    hold = 1; stored = 0;
    tick(2);
    send_line(2 * H, 0, 5, -1, 0);
    tick(4);
    check("buffered pixels held", int'(m_valid), 1);
    check("no overflow on drop", int'(overflow), 0);
    hold = 0;
    wait_drain();
    enable = 1'b1; m_en = 1;
    tick(2);
    send_line(2 * H, 0, -1, -1, 0);
    vsync_pulse();
    send_line(2 * H, 0, -1, -1, 0);
    send_line(2 * H, 0, -1, -1, 0);
    vsync_pulse();
    wait_drain();

    // Backpressure through two lines overflows the FIFO
    hold = 1; stored = 0;
    tick(2);
    send_line(2 * H, 0, -1, -1, 0);
    send_line(2 * H, 0, -1, -1, 0);
    tick(4);
    check("overflow set", int'(overflow), int'(m_ovf));
    check("full FIFO presents head", int'(m_valid), 1);
    hold = 0;
    wait_drain();
    vsync_pulse();
    send_line(2 * H, 0, -1, -1, 0);
    send_line(2 * H, 0, -1, -1, 0);
    vsync_pulse();
    wait_drain();
    check("overflow sticky", int'(overflow), 1);
    do_reset();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
